// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the requesters and the bus arbiter.
// With BUSARB_LOCK_EN defined the bundle also carries the lock request.
interface bus_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [5*NREQ-1:0] src_sel;
   logic [NREQ-1:0]   grant;
   logic [4:0]        Control;
   logic              bus_valid;
   logic              timeout;
`ifdef BUSARB_LOCK_EN
   logic              lock;
`endif

   modport master (
      output req, src_sel,
`ifdef BUSARB_LOCK_EN
      output lock,
`endif
      input  grant, Control, bus_valid, timeout
   );

   modport slave (
      input  req, src_sel,
`ifdef BUSARB_LOCK_EN
      input  lock,
`endif
      output grant, Control, bus_valid, timeout
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grants one requester, latches its 5-bit source code onto Control.
// Optional BUSARB_LOCK_EN adds a lock input that suppresses the MAX_HOLD forced release.
//
// state | meaning
// IDLE  | arbitrating, all outputs low
// GRANT | one requester owns the bus, Control frozen
// TURN  | single dead cycle after release, timeout may be high
module bus_arbiter #(
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 8
) (
   input logic             clk,
   input logic             clr_n,
   bus_arbiter_if.slave    bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t            state_q;
   logic [NREQ-1:0]   grant_q;
   logic [4:0]        ctrl_q;
   logic              bus_valid_q;
   logic              timeout_q;
   logic [PW-1:0]     ptr_q;
   logic [7:0]        cnt_q;

   logic [NREQ-1:0]   valid;
   logic              hit;
   logic [PW-1:0]     pick;
   logic [4:0]        pick_code;
   logic              cur_req;
   logic              lock_hold;

`ifdef BUSARB_LOCK_EN
   assign lock_hold = bus.lock;
`else
   assign lock_hold = 1'b0;
`endif

   // Codes 11000..11111 do not name a bus source, so such a request is ignored.
   always_comb begin
      valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         valid[i] = bus.req[i] & ~(bus.src_sel[5*i+4] & bus.src_sel[5*i+3]);
      end
   end

   always_comb begin
      logic [PW:0] idx;
      hit  = 1'b0;
      pick = '0;
      idx  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = {1'b0, ptr_q} + (PW+1)'(k);
         if (idx >= (PW+1)'(NREQ)) begin
            idx = idx - (PW+1)'(NREQ);
         end
         if (!hit && valid[idx[PW-1:0]]) begin
            hit  = 1'b1;
            pick = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      pick_code = 5'b00000;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == PW'(i)) begin
            pick_code = bus.src_sel[5*i +: 5];
         end
      end
   end

   // The owner keeps the bus on its raw req level; src_sel no longer matters once latched.
   assign cur_req = |(bus.req & grant_q);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         ctrl_q      <= 5'b00000;
         bus_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         ptr_q       <= PW'(NREQ-1);
         cnt_q       <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               timeout_q <= 1'b0;
               if (hit) begin
                  state_q     <= GRANT;
                  grant_q     <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
                  ctrl_q      <= pick_code;
                  bus_valid_q <= 1'b1;
                  ptr_q       <= pick;
                  cnt_q       <= 8'd1;
               end
            end
            GRANT: begin
               if (!cur_req) begin
                  state_q     <= TURN;
                  grant_q     <= '0;
                  ctrl_q      <= 5'b00000;
                  bus_valid_q <= 1'b0;
               end else if (cnt_q == 8'(MAX_HOLD) && !lock_hold) begin
                  state_q     <= TURN;
                  grant_q     <= '0;
                  ctrl_q      <= 5'b00000;
                  bus_valid_q <= 1'b0;
                  timeout_q   <= 1'b1;
               end else if (cnt_q != 8'(MAX_HOLD)) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            TURN: begin
               state_q   <= IDLE;
               timeout_q <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               grant_q     <= '0;
               ctrl_q      <= 5'b00000;
               bus_valid_q <= 1'b0;
               timeout_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.Control   = ctrl_q;
   assign bus.bus_valid = bus_valid_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 32-bit internal bus. Up to NREQ requesters (control unit, DMA, debug port, etc.) each ask to drive one bus source. The block grants one requester at a time and latches that requester's 5-bit source code. It drives the bus multiplexer's 5-bit Control select directly, replacing the priority encoder on multi-master paths.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_HOLD, 8, max consecutive GRANT cycles before forced release (2..255)

Ports:
clk  input  1  system clock, rising edge
clr_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester bus request, level
src_sel  input  5*NREQ  source code per requester; bits [5i+4:5i] belong to requester i
grant  output  NREQ  one-hot grant, registered
Control  output  5  bus mux select, registered
bus_valid  output  1  high while Control selects a granted source
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Clock and reset: one clock, clk. clr_n is asynchronous and active-low.
- While clr_n is low: grant=0, Control=5'b00000, bus_valid=0, timeout=0, state=IDLE, rr pointer=NREQ-1, hold counter=0. Outputs clear immediately, not at the next edge.
- Valid source codes are 5'b00000..5'b10111. A requester whose src_sel is 5'b11000..5'b11111 is treated as not requesting for that cycle.
- States: IDLE, GRANT, TURN.
- IDLE, arbitration:
  - Scan valid requesters in the order ptr+1, ptr+2, … (mod NREQ).
  - First hit i: on the next edge go to GRANT with grant=1<<i, Control=src_sel[i] (latched), bus_valid=1, ptr=i, counter=1.
  - Latency is 1 cycle from req sampled high to grant visible.
  - No valid req: stay in IDLE; all outputs 0.
- GRANT:
  - Control stays frozen at the latched code; later src_sel changes are ignored.
  - If req[i] is low at an edge: go to TURN, no timeout pulse.
  - If req[i] is high and counter==MAX_HOLD: go to TURN and assert timeout=1 during the TURN cycle.
  - Otherwise the counter increments.
  - A requester therefore drives the bus for at most MAX_HOLD cycles.
  - If req drops on the same edge the limit is reached, treat it as a normal release (timeout=0).
- TURN:
  - Exactly one dead cycle: grant=0, bus_valid=0, Control=5'b00000. No arbitration.
  - Always go to IDLE next, so there are two bus-idle cycles between consecutive grants.
  - timeout self-clears after TURN.
- Fairness: ptr updates only at grant. A requester that timed out is last in priority for the next arbitration.
- Simultaneous requests are resolved purely by the rr order; there is no fixed priority.
- grant is always one-hot or zero. bus_valid==|grant.

Optional Feature:
BUSARB_LOCK_EN
- Defined: adds input port lock (1 bit). While in GRANT with lock=1, the counter saturates and no forced release occurs. Release happens only via req drop. lock is ignored outside GRANT.
- Undefined: no lock port exists and MAX_HOLD is always enforced.

Test Plan:
1. Reset: hold clr_n=0 mid-stream with req=4'b1111 → grant=0, Control=0, bus_valid=0, timeout=0. After release, the first grant goes to requester 0.
2. Single grant: req=4'b0001, src_sel0=5'b10101, held 3 cycles then dropped → grant=0001 one cycle after req, Control=10101 with bus_valid=1 for 3 cycles, then 1 TURN cycle with zeros, then IDLE.
3. Round robin under saturation: req=4'b1111 held, MAX_HOLD=8 → grants in order 0,1,2,3,0. Each grant lasts 8 cycles and is followed by a timeout pulse, with 2 idle cycles between grants.
4. Frozen select: during a grant to requester 1 with src_sel1=5'b00011, change src_sel1 to 5'b10000 → Control stays 00011 until release.
5. Invalid code: req=4'b0110, src_sel1=5'b11000, src_sel2=5'b10100 → requester 2 granted with Control=10100. Requester 1 is never granted while its code is invalid.
6. With BUSARB_LOCK_EN: lock=1 and req0 held 20 cycles → bus_valid high for 20 cycles, no timeout. Without the macro the same stimulus yields a timeout at cycle 8.
